// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
//  Module   : serial_adder
//  Purpose  : Multi-cycle add/subtract unit. Processes DIGIT bits of two
//             WIDTH-bit operands per clock through a single DIGIT-bit
//             full-adder slice whose carry is held in a register. Operands
//             enter and the result leaves through valid/ready handshakes.
//  Ports    :
//    clk        in   rising-edge clock
//    rst_n      in   asynchronous active-low reset
//    in_valid   in   operand offer
//    in_ready   out  high while idle (operands can be accepted)
//    a, b       in   WIDTH-bit operands
//    cin        in   carry-in (borrow-in when sub=1)
//    sub        in   0: a+b+cin, 1: a-b-cin
//    out_valid  out  result available
//    out_ready  in   consumer accepts result
//    sum        out  WIDTH-bit result, modulo 2^WIDTH
//    cout       out  carry-out (1 = no borrow when subtracting)
//    ovf        out  two's-complement signed overflow
//  Revision : 1.0  initial release
// ============================================================================
module serial_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  // Guarded divisor keeps elaboration sane long enough for the check below
  // to report an illegal DIGIT instead of a divide-by-zero.
  localparam int C_DIV   = (DIGIT < 1) ? 1 : DIGIT;
  localparam int STEPS   = WIDTH / C_DIV;
  localparam int C_CNT_W = $clog2(STEPS) + 1;
  localparam logic [C_CNT_W-1:0] C_LAST = C_CNT_W'(STEPS - 1);

  if ((WIDTH < 2) || (DIGIT < 1) || ((WIDTH % C_DIV) != 0)) begin : g_bad_params
    $error("serial_adder: WIDTH must be >= 2 and DIGIT >= 1 must divide WIDTH");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [C_CNT_W-1:0]  r_cnt;
  logic [WIDTH-1:0]    r_a;
  logic [WIDTH-1:0]    r_b;       // already inverted when subtracting
  logic [WIDTH-1:0]    r_res;
  logic                r_carry;
  logic                r_sign_a;
  logic                r_sign_b;
  logic                r_ovf;

  logic [WIDTH-1:0]    w_b_eff;
  logic [DIGIT:0]      w_slice;   // {carry-out, digit sum}
  logic [DIGIT-1:0]    w_s;
  logic [WIDTH-1:0]    w_res_next;
  logic                w_last;

  // Subtraction is A + ~B + 1; a borrow-in removes the +1, hence cin ^ sub.
  assign w_b_eff = sub ? ~b : b;

  // The one shared full-adder slice.
  assign w_slice = {1'b0, r_a[DIGIT-1:0]}
                 + {1'b0, r_b[DIGIT-1:0]}
                 + {{DIGIT{1'b0}}, r_carry};
  assign w_s     = w_slice[DIGIT-1:0];
  assign w_last  = (r_cnt == C_LAST);

  // New digits enter at the top so that after STEPS shifts the least
  // significant digit has arrived at bit 0.
  if (DIGIT == WIDTH) begin : g_single_step
    assign w_res_next = w_s;
  end else begin : g_shift_step
    assign w_res_next = {w_s, r_res[WIDTH-1:DIGIT]};
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_state_next = RUN;
      RUN:     if (w_last)    w_state_next = DONE;
      DONE:    if (out_ready) w_state_next = IDLE;
      default:                w_state_next = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_carry  <= 1'b0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a      <= a;
            r_b      <= w_b_eff;
            r_carry  <= cin ^ sub;
            r_sign_a <= a[WIDTH-1];
            r_sign_b <= w_b_eff[WIDTH-1];
            r_cnt    <= '0;
          end
        end
        RUN: begin
          r_carry <= w_slice[DIGIT];
          r_a     <= r_a >> DIGIT;
          r_b     <= r_b >> DIGIT;
          r_res   <= w_res_next;
          r_cnt   <= r_cnt + C_CNT_W'(1);
          // On the final step the top digit's MSB is the result sign, so the
          // overflow flag can be registered together with the result.
          if (w_last) begin
            r_ovf <= (r_sign_a == r_sign_b) && (w_s[DIGIT-1] != r_sign_a);
          end
        end
        default: begin
          // DONE: hold everything until the consumer takes the result.
        end
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign sum       = r_res;
  assign cout      = r_carry;
  assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_adder
//  Purpose  : Self-checking bench for serial_adder. Drives a DIGIT=1 and a
//             DIGIT=4 instance (both WIDTH=16) with directed vectors, a
//             backpressure scenario, an asynchronous mid-operation reset and
//             a short random run checked against an integer reference.
//  Revision : 1.0  initial release
// ============================================================================
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // DIGIT=1 instance
  logic        iv1 = 1'b0, ir1, ov1, ordy1 = 1'b0, cin1 = 1'b0, sub1 = 1'b0, co1, of1;
  logic [15:0] a1 = '0, b1 = '0, s1;
  // DIGIT=4 instance
  logic        iv4 = 1'b0, ir4, ov4, ordy4 = 1'b0, cin4 = 1'b0, sub4 = 1'b0, co4, of4;
  logic [15:0] a4 = '0, b4 = '0, s4;

  serial_adder #(.WIDTH(16), .DIGIT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
    .cin(cin1), .sub(sub1), .out_valid(ov1), .out_ready(ordy1),
    .sum(s1), .cout(co1), .ovf(of1)
  );

  serial_adder #(.WIDTH(16), .DIGIT(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
    .cin(cin4), .sub(sub4), .out_valid(ov4), .out_ready(ordy4),
    .sum(s4), .cout(co4), .ovf(of4)
  );

  // Selected instance view
  int          sel = 0;
  logic        c_ir, c_ov;
  logic [17:0] c_res;   // {cout, ovf, sum}
  assign c_ir  = (sel == 0) ? ir1 : ir4;
  assign c_ov  = (sel == 0) ? ov1 : ov4;
  assign c_res = (sel == 0) ? {co1, of1, s1} : {co4, of4, s4};

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_in(input logic v, input logic [15:0] av, input logic [15:0] bv,
                        input logic c, input logic s);
    if (sel == 0) begin iv1 = v; a1 = av; b1 = bv; cin1 = c; sub1 = s; end
    else          begin iv4 = v; a4 = av; b4 = bv; cin4 = c; sub4 = s; end
  endtask

  task automatic set_ordy(input logic r);
    if (sel == 0) ordy1 = r; else ordy4 = r;
  endtask

  // Offer operands until accepted (bounded); returns at edge-of-accept + 1.
  task automatic start(input logic [15:0] av, input logic [15:0] bv,
                       input logic c, input logic s, input string tag);
    int n = 0;
    while (!c_ir && n < 60) begin
      @(posedge clk); #1; n++;
    end
    if (!c_ir) chk({tag, "_accept_timeout"}, 0, 1);
    set_in(1'b1, av, bv, c, s);
    @(posedge clk); #1;
    set_in(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
  endtask

  // Directed op: checks latency, in_ready low while busy, and result.
  task automatic run_op(input logic [15:0] av, input logic [15:0] bv, input logic c,
                        input logic s, input int steps, input logic [15:0] esum,
                        input logic ecout, input logic eovf, input string tag,
                        input bit hold);
    int lat = 0;
    logic busy_ok = 1'b1;
    start(av, bv, c, s, tag);
    while (!c_ov && lat < 60) begin
      if (c_ir) busy_ok = 1'b0;
      @(posedge clk); #1; lat++;
    end
    chk({tag, "_latency"}, lat, steps);
    chk({tag, "_inready_low"}, busy_ok, 1);
    chk({tag, "_sum"}, c_res[15:0], esum);
    chk({tag, "_cout_ovf"}, c_res[17:16], {ecout, eovf});
    if (!hold) begin
      set_ordy(1'b1);
      @(posedge clk); #1;
      set_ordy(1'b0);
    end
  endtask

  function automatic logic [17:0] ref_op(input logic [15:0] av, input logic [15:0] bv,
                                         input logic c, input logic s);
    int sa = int'($signed(av));
    int sb = int'($signed(bv));
    int r;
    logic [16:0] u;
    logic co;
    if (!s) begin
      u  = {1'b0, av} + {1'b0, bv} + 17'(c);
      co = u[16];
      r  = sa + sb + int'(c);
    end else begin
      u  = {1'b0, av} - {1'b0, bv} - 17'(c);
      co = ~u[16];
      r  = sa - sb - int'(c);
    end
    return {co, (r > 32767) || (r < -32768), u[15:0]};
  endfunction

  initial begin
    logic [17:0] held;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    // Reset state
    chk("rst_inready1", ir1, 1);
    chk("rst_outvalid1", ov1, 0);
    chk("rst_outs1", {co1, of1, s1}, 0);
    chk("rst_inready4", ir4, 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed, DIGIT=1
    sel = 0;
    run_op(16'h1234, 16'h0FED, 0, 0, 16, 16'h2221, 0, 0, "add_basic", 0);
    run_op(16'h7FFF, 16'h0001, 0, 0, 16, 16'h8000, 0, 1, "add_ovf", 0);
    run_op(16'hFFFF, 16'h0001, 1, 0, 16, 16'h0001, 1, 0, "add_cin", 0);
    run_op(16'h0005, 16'h0007, 0, 1, 16, 16'hFFFE, 0, 0, "sub_borrow", 0);
    run_op(16'h8000, 16'h0001, 0, 1, 16, 16'h7FFF, 1, 1, "sub_ovf", 0);

    // Backpressure: hold result, offer other operands, they must be ignored
    run_op(16'h0100, 16'h0200, 0, 0, 16, 16'h0300, 0, 0, "bp", 1);
    held = c_res;
    for (int i = 0; i < 5; i++) begin
      set_in(1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
      @(posedge clk); #1;
      chk("bp_outvalid", c_ov, 1);
      chk("bp_inready", c_ir, 0);
      chk("bp_hold", c_res, {2'b00, 16'h0300});
    end
    set_in(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    chk("bp_held_vs_first", c_res, held);
    set_ordy(1'b1);
    @(posedge clk); #1;
    set_ordy(1'b0);
    chk("bp_release_inready", c_ir, 1);
    chk("bp_release_outvalid", c_ov, 0);

    // Asynchronous reset in the middle of RUN
    start(16'hF0F0, 16'h0F0F, 0, 0, "rst_mid");
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rstmid_outvalid", ov1, 0);
    chk("rstmid_inready", ir1, 1);
    chk("rstmid_sum", s1, 16'h0000);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(16'h00FF, 16'h0001, 0, 0, 16, 16'h0100, 0, 0, "after_rst", 0);

    // Directed, DIGIT=4
    sel = 1;
    run_op(16'hABCD, 16'h1111, 0, 0, 4, 16'hBCDE, 0, 0, "d4_add", 0);
    run_op(16'h8000, 16'h0001, 0, 1, 4, 16'h7FFF, 1, 1, "d4_sub_ovf", 0);

    // Random run against integer reference, random out_ready
    for (int n = 0; n < 300; n++) begin
      logic [15:0] ra, rb;
      logic rc, rs;
      int k;
      sel = n % 2;
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      rs = 1'($urandom);
      start(ra, rb, rc, rs, "rnd");
      k = 0;
      while (!c_ov && k < 40) begin
        set_ordy(1'($urandom));
        @(posedge clk); #1; k++;
      end
      chk("rnd_result", c_res, ref_op(ra, rb, rc, rs));
      k = 0;
      while (c_ov && k < 40) begin
        logic r;
        r = 1'($urandom);
        set_ordy(r);
        @(posedge clk); #1; k++;
        if (r) break;
      end
      set_ordy(1'b0);
      if (c_ov) chk("rnd_drain_timeout", 0, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
